pipe_barrel_shifter: RTL
========================

Name: pipe_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter. Successor to the team's 8-bit combinational shifter.
- Adds configurable width, three shift modes, pipeline valid tracking, a global stall enable, and carry/zero flags.
- Intended as the shift unit feeding the datapath ALU result mux. Accepts one operation per cycle.

Parameters:
- WIDTH, 8, data width in bits; must be a power of 2 and >= 4.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  pipeline advance; 0 freezes every register.
- in_valid  input  1  qualifies inp/shamt/dir/mode this cycle.
- inp  input  WIDTH  operand.
- shamt  input  SHW  shift amount, 0..WIDTH-1.
- dir  input  1  0 = left, 1 = right.
- mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 pass-through.
- outp  output  WIDTH  shifted result.
- out_valid  output  1  outp/carry/zero valid this cycle.
- carry  output  1  last bit shifted out.
- zero  output  1  outp == 0.

Behaviour:
- Reset: async, active-high, one clock (clk). While rst=1, all pipeline registers clear: outp=0, out_valid=0, carry=0, zero=0. Applies immediately, independent of clk.
- Structure: SHW registered stages. Stage k (k=0..SHW-1) shifts by 2^k when shamt[k]=1, otherwise passes. dir, mode, residual shamt bits, valid and carry travel with the data.
- Latency: exactly SHW enabled cycles from input acceptance to out_valid (3 for WIDTH=8). Throughput is 1 op per enabled cycle. No bubbles are inserted.
- Acceptance: an input is captured on a rising edge with en=1. in_valid=0 captures a bubble, which yields out_valid=0 at output.
- Stall: en=0 holds every stage, including outputs, unchanged. Inputs presented during a stall are ignored.
- Mode rules:
  - Logical: vacated bits are 0.
  - Arithmetic right: vacated bits copy inp[WIDTH-1]. Arithmetic left is identical to logical left.
  - Rotate: no bits lost. Shifted-out bits re-enter at the opposite end.
  - Pass-through (11): outp=inp and carry=0, regardless of shamt/dir.
- Carry, computed in stage 0 from the original operand (n = shamt):
  - n=0: carry=0.
  - Left, n>0: carry = inp[WIDTH-n].
  - Right, n>0: carry = inp[n-1].
  - Rotate uses the same index rule.
- Zero: computed on the final-stage result and registered with it. Zero=1 only when outp==0. It is meaningful only when out_valid=1 and is held 0 when out_valid=0.
- Boundaries:
  - shamt=0 returns inp in all modes.
  - shamt=WIDTH-1 is the maximum. No wrap of shamt beyond SHW bits.
- Reset mid-operation flushes all in-flight ops. No op is output after rst deasserts until new inputs traverse the pipe.
- rst deassertion: the first accepting edge occurs on the first clk edge with rst=0 and en=1.
- Outputs are fully registered. No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, inp=11011011, shamt=5, dir=0, mode=00 -> after 3 cycles: outp=01100000, carry=1, zero=0, out_valid=1 for one cycle.
- Same inp, shamt=5, dir=1, mode=01 -> outp=11111110, carry=1. With mode=00 -> outp=00000110, carry=1.
- Same inp, shamt=5, dir=1, mode=10 -> outp=11011110, carry=1. With shamt=0 in any mode -> outp=11011011, carry=0.
- inp=00000001, shamt=1, dir=1, mode=00 -> outp=00000000, carry=1, zero=1.
- Back-to-back stream of 4 ops, with en=0 for 2 cycles mid-stream:
  - Results appear in order with no loss or duplication.
  - outputs are frozen during the stall.
  - total latency = 3 + 2 cycles for ops in flight.
- Assert rst asynchronously between clock edges with 2 ops in flight:
  - outp/out_valid/carry/zero go to 0 immediately.
  - no stale result appears after release.

Source files
------------

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, with
// logical/arithmetic/rotate/pass-through modes and carry/zero flags.
module pipe_barrel_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] inp,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] outp,
  output logic             out_valid,
  output logic             carry,
  output logic             zero
);

  localparam int          NSTG      = int'(SHW);
  localparam logic [1:0]  MODE_LOG  = 2'b00;
  localparam logic [1:0]  MODE_ARI  = 2'b01;
  localparam logic [1:0]  MODE_ROT  = 2'b10;
  localparam logic [1:0]  MODE_PASS = 2'b11;

  // Per-stage registers; control fields are not needed after the last stage.
  logic [WIDTH-1:0] r_data  [NSTG];
  logic             r_valid [NSTG];
  logic             r_carry [NSTG];
  logic             r_dir   [NSTG-1];
  logic [1:0]       r_mode  [NSTG-1];
  logic [SHW-1:0]   r_shamt [NSTG-1];
  logic             r_zero;

  logic [WIDTH-1:0] w_in_data  [NSTG];
  logic             w_in_valid [NSTG];
  logic             w_in_carry [NSTG];
  logic             w_in_dir   [NSTG];
  logic [1:0]       w_in_mode  [NSTG];
  logic [SHW-1:0]   w_in_shamt [NSTG];
  logic [WIDTH-1:0] w_nx_data  [NSTG];
  logic             w_nx_zero;
  logic             w_carry0;
  logic [SHW-1:0]   w_cidx;

  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] d,
    input int               k,
    input logic             do_sh,
    input logic             sh_dir,
    input logic [1:0]       sh_mode
  );
    int amt;
    amt = 1 << k;
    if (!do_sh || sh_mode == MODE_PASS) begin
      return d;
    end
    if (!sh_dir) begin
      if (sh_mode == MODE_ROT) return (d << amt) | (d >> (WIDTH - amt));
      return d << amt;
    end
    if (sh_mode == MODE_ROT) return (d >> amt) | (d << (WIDTH - amt));
    if (sh_mode == MODE_ARI) return WIDTH'($signed(d) >>> amt);
    return d >> amt;
  endfunction

  // Carry index wraps modulo WIDTH, so 0 - n selects bit WIDTH-n for left shifts.
  always_comb begin
    w_cidx   = dir ? (shamt - SHW'(1)) : (SHW'(0) - shamt);
    w_carry0 = 1'b0;
    if (mode != MODE_PASS && shamt != '0) begin
      w_carry0 = inp[w_cidx];
    end
  end

  always_comb begin
    w_in_data[0]  = inp;
    w_in_valid[0] = in_valid;
    w_in_carry[0] = w_carry0;
    w_in_dir[0]   = dir;
    w_in_mode[0]  = mode;
    w_in_shamt[0] = shamt;
    for (int k = 1; k < NSTG; k++) begin
      w_in_data[k]  = r_data[k-1];
      w_in_valid[k] = r_valid[k-1];
      w_in_carry[k] = r_carry[k-1];
      w_in_dir[k]   = r_dir[k-1];
      w_in_mode[k]  = r_mode[k-1];
      w_in_shamt[k] = r_shamt[k-1];
    end
  end

  // Residual shamt is shifted down each stage, so bit 0 always selects this stage.
  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      w_nx_data[k] = stage_shift(w_in_data[k], k, w_in_shamt[k][0],
                                 w_in_dir[k], w_in_mode[k]);
    end
    w_nx_zero = w_in_valid[NSTG-1] && (w_nx_data[NSTG-1] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) begin
        r_data[k]  <= '0;
        r_valid[k] <= 1'b0;
        r_carry[k] <= 1'b0;
      end
      for (int k = 0; k < NSTG - 1; k++) begin
        r_dir[k]   <= 1'b0;
        r_mode[k]  <= MODE_LOG;
        r_shamt[k] <= '0;
      end
      r_zero <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < NSTG; k++) begin
        r_data[k]  <= w_nx_data[k];
        r_valid[k] <= w_in_valid[k];
        r_carry[k] <= w_in_carry[k];
      end
      for (int k = 0; k < NSTG - 1; k++) begin
        r_dir[k]   <= w_in_dir[k];
        r_mode[k]  <= w_in_mode[k];
        r_shamt[k] <= w_in_shamt[k] >> 1;
      end
      r_zero <= w_nx_zero;
    end
  end

  assign outp      = r_data[NSTG-1];
  assign out_valid = r_valid[NSTG-1];
  assign carry     = r_carry[NSTG-1];
  assign zero      = r_zero;

endmodule
